// File: rtl/div_ctrl_if.sv
// Request/response channels of the iterative divider controller.
// in_signed exists only when DIV_SIGNED_EN is defined.
interface div_ctrl_if;
    // Both channels: a transfer happens on the rising clock edge where valid and
    // ready are both high; valid, once raised, holds its payload stable until that edge.
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_dividend;
    logic [31:0] in_divisor;
`ifdef DIV_SIGNED_EN
    logic        in_signed;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_quotient;
    logic [31:0] out_remainder;
    logic        out_dbz;

    modport slave (
        input  in_valid, in_dividend, in_divisor,
`ifdef DIV_SIGNED_EN
        input  in_signed,
`endif
        input  out_ready,
        output in_ready, out_valid, out_quotient, out_remainder, out_dbz
    );

    modport master (
        output in_valid, in_dividend, in_divisor,
`ifdef DIV_SIGNED_EN
        output in_signed,
`endif
        output out_ready,
        input  in_ready, out_valid, out_quotient, out_remainder, out_dbz
    );
endinterface

// File: rtl/div_ctrl.sv
// Sequencer for a 32-bit restoring divider datapath: load, 32 steps, capture, respond.
// Optional signed wrapper enabled by defining DIV_SIGNED_EN.
module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    div_ctrl_if.slave   bus,
    output logic        busy,
    output logic        dp_load,
    output logic        dp_step,
    output logic [31:0] dp_dividend,
    output logic [31:0] dp_divisor,
    input  logic [31:0] dp_quotient,
    input  logic [31:0] dp_remainder,
    output logic [2:0]  o_dbg_state
);

    localparam logic [31:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [5:0]  r_step_cnt;
    logic [31:0] r_dp_dividend;
    logic [31:0] r_dp_divisor;
    logic [31:0] r_quotient;
    logic [31:0] r_remainder;
    logic        r_dbz;

    logic        w_accept;
    logic        w_div_zero;
    logic        w_last_step;
    logic [31:0] w_dvd_mag;
    logic [31:0] w_dvs_mag;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    assign w_accept    = (r_state == S_IDLE) && bus.in_valid;
    assign w_div_zero  = (bus.in_divisor == 32'd0);
    assign w_last_step = (r_step_cnt == 6'd31);

`ifdef DIV_SIGNED_EN
    logic w_dvd_neg;
    logic w_dvs_neg;
    logic r_neg_q;
    logic r_neg_r;

    assign w_dvd_neg = bus.in_signed & bus.in_dividend[31];
    assign w_dvs_neg = bus.in_signed & bus.in_divisor[31];
    // -2^31 maps to 32'h8000_0000, which the unsigned datapath handles as-is.
    assign w_dvd_mag = w_dvd_neg ? (~bus.in_dividend + 32'd1) : bus.in_dividend;
    assign w_dvs_mag = w_dvs_neg ? (~bus.in_divisor + 32'd1) : bus.in_divisor;
    assign w_quo_fix = r_neg_q ? (~dp_quotient + 32'd1) : dp_quotient;
    assign w_rem_fix = r_neg_r ? (~dp_remainder + 32'd1) : dp_remainder;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
        end
    end
`else
    assign w_dvd_mag = bus.in_dividend;
    assign w_dvs_mag = bus.in_divisor;
    assign w_quo_fix = dp_quotient;
    assign w_rem_fix = dp_remainder;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_state_nxt = w_div_zero ? S_RESP : S_LOAD;
                end
            end
            S_LOAD:    w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_last_step) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: w_state_nxt = S_RESP;
            S_RESP: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fixed 32-step count; the datapath's own done flag is deliberately ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step_cnt <= 6'd0;
        end else if (r_state == S_LOAD) begin
            r_step_cnt <= 6'd0;
        end else if (r_state == S_RUN) begin
            r_step_cnt <= r_step_cnt + 6'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dp_dividend <= 32'd0;
            r_dp_divisor  <= 32'd0;
        end else if (w_accept) begin
            r_dp_dividend <= w_dvd_mag;
            r_dp_divisor  <= w_dvs_mag;
        end
    end

    // Divide-by-zero bypasses the datapath and reports the raw dividend.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quotient  <= 32'd0;
            r_remainder <= 32'd0;
            r_dbz       <= 1'b0;
        end else if (w_accept && w_div_zero) begin
            r_quotient  <= DBZ_QUOTIENT;
            r_remainder <= bus.in_dividend;
            r_dbz       <= 1'b1;
        end else if (r_state == S_CAPTURE) begin
            r_quotient  <= w_quo_fix;
            r_remainder <= w_rem_fix;
            r_dbz       <= 1'b0;
        end
    end

    assign bus.in_ready      = (r_state == S_IDLE);
    assign bus.out_valid     = (r_state == S_RESP);
    assign bus.out_quotient  = r_quotient;
    assign bus.out_remainder = r_remainder;
    assign bus.out_dbz       = r_dbz;

    assign busy        = (r_state != S_IDLE);
    assign dp_load     = (r_state == S_LOAD);
    assign dp_step     = (r_state == S_RUN);
    assign dp_dividend = r_dp_dividend;
    assign dp_divisor  = r_dp_divisor;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: restoring-divider datapath model, directed and random requests,
// expected-result queue checked by an independent response monitor.
module tb_div_ctrl;

  localparam int LAT = 35;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_ctrl_if bus();

  logic        busy;
  logic        dp_load;
  logic        dp_step;
  logic [31:0] dp_dividend;
  logic [31:0] dp_divisor;
  logic [31:0] dp_quotient;
  logic [31:0] dp_remainder;
  logic [2:0]  dbg_state;

  div_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy         (busy),
    .dp_load      (dp_load),
    .dp_step      (dp_step),
    .dp_dividend  (dp_dividend),
    .dp_divisor   (dp_divisor),
    .dp_quotient  (dp_quotient),
    .dp_remainder (dp_remainder),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- datapath model: one restoring step per dp_step ----------------
  logic [31:0] dm_quo = 32'd0;
  logic [31:0] dm_rem = 32'd0;
  always @(posedge clk) begin : dp_model
    logic [32:0] t;
    logic [32:0] d;
    if (dp_load) begin
      dm_rem <= 32'd0;
      dm_quo <= dp_dividend;
    end else if (dp_step) begin
      t = {dm_rem, dm_quo[31]};
      d = t - {1'b0, dp_divisor};
      if (t >= {1'b0, dp_divisor}) begin
        dm_rem <= d[31:0];
        dm_quo <= {dm_quo[30:0], 1'b1};
      end else begin
        dm_rem <= t[31:0];
        dm_quo <= {dm_quo[30:0], 1'b0};
      end
    end
  end
  assign dp_quotient  = dm_quo;
  assign dp_remainder = dm_rem;

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [64:0] exp_q[$];
  int          exp_cyc_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division; signed uses truncation toward zero.
  function automatic logic [64:0] ref_div(input logic [31:0] dvd, input logic [31:0] dvs,
                                          input logic sgn);
    longint a, b, q, r;
    if (dvs == 32'd0) return {1'b1, 32'hFFFF_FFFF, dvd};
    if (sgn) begin
      a = longint'($signed(dvd));
      b = longint'($signed(dvs));
    end else begin
      a = longint'({32'd0, dvd});
      b = longint'({32'd0, dvs});
    end
    q = a / b;
    r = a % b;
    return {1'b0, q[31:0], r[31:0]};
  endfunction

  // ---------------- out_ready driver ----------------
  logic rand_rdy   = 1'b0;
  logic forced_rdy = 1'b1;
  always @(posedge clk) begin
    #1;
    bus.out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : forced_rdy;
  end

  // ---------------- request driver ----------------
  task automatic send(input logic [31:0] dvd, input logic [31:0] dvs, input logic sgn,
                      output int acc);
    bit   got;
    logic sgn_eff;
    got = 0;
    acc = -1;
`ifdef DIV_SIGNED_EN
    sgn_eff = sgn;
`else
    sgn_eff = 1'b0;
`endif
    @(posedge clk);
    #1;
    bus.in_valid    = 1'b1;
    bus.in_dividend = dvd;
    bus.in_divisor  = dvs;
`ifdef DIV_SIGNED_EN
    bus.in_signed   = sgn;
`endif
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1;
        acc = cyc;
        exp_q.push_back(ref_div(dvd, dvs, sgn_eff));
        exp_cyc_q.push_back(cyc + ((dvs == 32'd0) ? 1 : LAT));
      end
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL send_accept: in_ready never seen for %h/%h", dvd, dvs);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.in_ready) done = 1;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL drain: %0d responses still outstanding", exp_q.size());
    end
  endtask

  // ---------------- response monitor ----------------
  bit          in_resp  = 0;
  bit          hold     = 0;
  bit          hs_prev  = 0;
  bit          unstable = 0;
  bit          overlap  = 0;
  int          n_load   = 0;
  int          n_step   = 0;
  logic [31:0] ld_dvd   = 32'd0;
  logic [31:0] ld_dvs   = 32'd0;
  logic [31:0] h_q, h_r;
  logic        h_dbz;
  logic [64:0] e;
  int          ec;

  always @(negedge clk) begin
    if (rst) begin
      in_resp = 0;
      hold    = 0;
      hs_prev = 0;
    end else begin
      if (hs_prev) begin
        chk("in_ready_after_handshake", 32'(bus.in_ready), 32'd1);
        chk("out_valid_after_handshake", 32'(bus.out_valid), 32'd0);
      end
      if (hold) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_quotient", bus.out_quotient, h_q);
        chk("hold_remainder", bus.out_remainder, h_r);
        chk("hold_dbz", 32'(bus.out_dbz), 32'(h_dbz));
        chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      if (bus.in_valid && bus.in_ready) begin
        n_load   = 0;
        n_step   = 0;
        unstable = 0;
        overlap  = 0;
      end else begin
        if (dp_load && dp_step) overlap = 1;
        if (dp_load) begin
          n_load++;
          ld_dvd = dp_dividend;
          ld_dvs = dp_divisor;
        end
        if (dp_step) begin
          n_step++;
          if (dp_dividend != ld_dvd || dp_divisor != ld_dvs) unstable = 1;
        end
      end
      if (bus.out_valid && !in_resp) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_response: q=%h r=%h", bus.out_quotient, bus.out_remainder);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          chk("quotient", bus.out_quotient, e[63:32]);
          chk("remainder", bus.out_remainder, e[31:0]);
          chk("dbz", 32'(bus.out_dbz), 32'(e[64]));
          chk("latency_cycle", 32'(cyc), 32'(ec));
          chk("load_count", 32'(n_load), e[64] ? 32'd0 : 32'd1);
          chk("step_count", 32'(n_step), e[64] ? 32'd0 : 32'd32);
          chk("operands_stable", 32'(unstable), 32'd0);
          chk("load_step_overlap", 32'(overlap), 32'd0);
        end
        in_resp = 1;
      end
      hs_prev = bus.out_valid && bus.out_ready;
      hold    = bus.out_valid && !bus.out_ready;
      h_q     = bus.out_quotient;
      h_r     = bus.out_remainder;
      h_dbz   = bus.out_dbz;
      if (hs_prev) in_resp = 0;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int a0, a1, acc;
    logic [31:0] dvd, dvs;
    logic        sgn;
    bit          seen;
    bus.in_valid    = 1'b0;
    bus.in_dividend = 32'd0;
    bus.in_divisor  = 32'd0;
`ifdef DIV_SIGNED_EN
    bus.in_signed   = 1'b0;
`endif
    bus.out_ready   = 1'b1;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dp_load", 32'(dp_load), 32'd0);
    chk("rst_dp_step", 32'(dp_step), 32'd0);
    chk("rst_out_dbz", 32'(bus.out_dbz), 32'd0);
    chk("rst_quotient", bus.out_quotient, 32'd0);
    chk("rst_remainder", bus.out_remainder, 32'd0);
    chk("rst_dp_dividend", dp_dividend, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset in the middle of RUN discards the operation
    send(32'd100, 32'd7, 1'b0, acc);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_dp_step", 32'(dp_step), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    exp_cyc_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);

    // Plain 100/7 after the reset
    send(32'd100, 32'd7, 1'b0, acc);
    wait_drain();

    // Back-to-back with out_ready high: one result per 36 cycles
    send(32'hFFFF_FFFF, 32'd1, 1'b0, a0);
    send(32'd5, 32'd9, 1'b0, a1);
    chk("b2b_accept_spacing", 32'(a1 - a0), 32'd36);
    wait_drain();

    // Divide by zero
    send(32'd1234, 32'd0, 1'b0, acc);
    wait_drain();

    // Backpressure with a request held on in_valid while busy
    forced_rdy = 1'b0;
    send(32'd100, 32'd7, 1'b0, acc);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    chk("bp_response_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid    = 1'b1;
    bus.in_dividend = 32'd55;
    bus.in_divisor  = 32'd3;
    repeat (20) begin
      @(negedge clk);
      chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    end
    forced_rdy = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_drain();

`ifdef DIV_SIGNED_EN
    send(32'hFFFF_FFF9, 32'd2, 1'b1, acc);
    send(32'd7, 32'hFFFF_FFFE, 1'b1, acc);
    send(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, acc);
    send(32'hFFFF_FFF9, 32'd2, 1'b0, acc);
    send(32'hFFFF_FFF9, 32'd0, 1'b1, acc);
    wait_drain();
`endif

    // Randomized traffic with random backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 60; n++) begin
      dvd = $urandom;
      case ($urandom_range(0, 7))
        0:       dvs = 32'd0;
        1, 2, 3: dvs = 32'($urandom_range(1, 15));
        default: dvs = $urandom;
      endcase
`ifdef DIV_SIGNED_EN
      sgn = 1'($urandom_range(0, 1));
`else
      sgn = 1'b0;
`endif
      send(dvd, dvs, sgn, acc);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(posedge clk);
    end
    wait_drain();
    rand_rdy = 1'b0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
